// File: rtl/id_ex_control_stage.sv
// ID-stage main control decode for an RV64 subset (add/sub/and/or, ld, sd, beq)
// followed by the ID/EX pipeline register with stall (hold) and flush (bubble).
module id_ex_control_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  output logic [1:0]      ex_aluOp_o,
  output logic            ex_aluSrc_o,
  output logic            ex_memRead_o,
  output logic            ex_memWrite_o,
  output logic            ex_regWrite_o,
  output logic            ex_memToReg_o,
  output logic            ex_branch_o,
  output logic [2:0]      ex_funct3_o,
  output logic [6:0]      ex_funct7_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic            ex_illegal_o
);

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpLd  = 7'b0000011;
  localparam logic [6:0] OpSd  = 7'b0100011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } idex_t;

  idex_t      dec;
  idex_t      idex_d;
  idex_t      idex_q;
  logic [6:0] opcode;

  assign opcode = instr_i[6:0];

  // An all-zero record is the bubble; an invalid slot decodes straight to it.
  always_comb begin
    dec = '0;
    if (valid_i) begin
      dec.valid  = 1'b1;
      dec.funct3 = instr_i[14:12];
      dec.funct7 = instr_i[31:25];
      dec.rs1    = instr_i[19:15];
      dec.rs2    = instr_i[24:20];
      dec.rd     = instr_i[11:7];
      dec.pc     = pc_i;
      case (opcode)
        OpR: begin
          dec.alu_op    = AluFunct;
          dec.reg_write = 1'b1;
        end
        OpLd: begin
          dec.alu_op     = AluAdd;
          dec.alu_src    = 1'b1;
          dec.mem_read   = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.imm        = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        end
        OpSd: begin
          dec.alu_op    = AluAdd;
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          dec.imm       = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end
        OpBeq: begin
          dec.alu_op = AluSub;
          dec.branch = 1'b1;
          dec.imm    = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
        end
        default: begin
          // Unsupported opcode travels as a NOP flagged illegal.
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (!stall_i) begin
      idex_d = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid_o    = idex_q.valid;
  assign ex_aluOp_o    = idex_q.alu_op;
  assign ex_aluSrc_o   = idex_q.alu_src;
  assign ex_memRead_o  = idex_q.mem_read;
  assign ex_memWrite_o = idex_q.mem_write;
  assign ex_regWrite_o = idex_q.reg_write;
  assign ex_memToReg_o = idex_q.mem_to_reg;
  assign ex_branch_o   = idex_q.branch;
  assign ex_funct3_o   = idex_q.funct3;
  assign ex_funct7_o   = idex_q.funct7;
  assign ex_rs1_o      = idex_q.rs1;
  assign ex_rs2_o      = idex_q.rs2;
  assign ex_rd_o       = idex_q.rd;
  assign ex_imm_o      = idex_q.imm;
  assign ex_pc_o       = idex_q.pc;
  assign ex_illegal_o  = idex_q.illegal;

endmodule
